id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 179 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with ALU control decode and
// operand forwarding.
//
// Captures a decoded instruction on each rising clk. stall holds the
// stage. flush, or inValid=0, loads a bubble. aluControl is decoded at
// capture time. Operands are selected combinationally from the
// registered values. When forwarding is enabled, EX/MEM and MEM/WB
// results are forwarded onto the registered rs/rt numbers.
//
// Build option: define FORWARDING_EN to enable operand forwarding.
// Without it, operands come only from the registered read data, and
// the exMem*/memWb* ports are still present but ignored.
//
// Ports:
//   clk, rstN                       clock, async active-low reset
//   stall, flush, inValid           stage control
//   rsData, rtData, immExt          operand sources (DATA_W)
//   rsAddr, rtAddr, rdAddr, shamt   register numbers / shift amount
//   funct, aluOp, aluSrc, regWriteIn  decode control
//   exMem*, memWb*                  later-stage writeback info
//   in1, in2, storeData             ALU operands / store data
//   aluControl, destRd              registered decode results
//   regWriteOut, outValid, illegalFunct  registered control/status
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              stall,
    input  logic              flush,
    input  logic              inValid,
    input  logic [DATA_W-1:0] rsData,
    input  logic [DATA_W-1:0] rtData,
    input  logic [DATA_W-1:0] immExt,
    input  logic [4:0]        rsAddr,
    input  logic [4:0]        rtAddr,
    input  logic [4:0]        rdAddr,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [1:0]        aluOp,
    input  logic              aluSrc,
    input  logic              regWriteIn,
    input  logic              exMemRegWrite,
    input  logic              memWbRegWrite,
    input  logic [4:0]        exMemRd,
    input  logic [4:0]        memWbRd,
    input  logic [DATA_W-1:0] exMemResult,
    input  logic [DATA_W-1:0] memWbResult,
    output logic [DATA_W-1:0] in1,
    output logic [DATA_W-1:0] in2,
    output logic [3:0]        aluControl,
    output logic [DATA_W-1:0] storeData,
    output logic [4:0]        destRd,
    output logic              regWriteOut,
    output logic              outValid,
    output logic              illegalFunct
);

    // Whole stage in one struct, so reset and bubble are a single '0 load.
    typedef struct packed {
        logic              valid;
        logic              regWrite;
        logic              illegal;
        logic              isShift;
        logic              aluSrc;
        logic [3:0]        aluCtl;
        logic [4:0]        rd;
        logic [4:0]        rsAddr;
        logic [4:0]        rtAddr;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] rs;
        logic [DATA_W-1:0] rt;
        logic [DATA_W-1:0] imm;
    } stage_t;

    stage_t stage_q, stage_d;
    logic [3:0] aluCtl_d;
    logic       illegal_d;
    logic       isShift_d;

    always_comb begin
        aluCtl_d  = 4'b0010;
        illegal_d = 1'b0;
        isShift_d = 1'b0;
        unique case (aluOp)
            2'b00: aluCtl_d = 4'b0010;
            2'b01: aluCtl_d = 4'b0110;
            2'b11: aluCtl_d = 4'b0001;
            default: begin
                case (funct)
                    6'b100000: aluCtl_d = 4'b0010;
                    6'b100010: aluCtl_d = 4'b0110;
                    6'b100100: aluCtl_d = 4'b0000;
                    6'b100101: aluCtl_d = 4'b0001;
                    6'b101010: aluCtl_d = 4'b0111;
                    6'b100111: aluCtl_d = 4'b1100;
                    6'b000000: begin aluCtl_d = 4'b1111; isShift_d = 1'b1; end
                    6'b000010: begin aluCtl_d = 4'b1110; isShift_d = 1'b1; end
                    // Unknown R-type: safe add, flagged, and never writes back.
                    default:   begin aluCtl_d = 4'b0010; illegal_d = 1'b1; end
                endcase
            end
        endcase
    end

    always_comb begin
        stage_d          = '0;
        stage_d.valid    = 1'b1;
        stage_d.regWrite = regWriteIn & ~illegal_d;
        stage_d.illegal  = illegal_d;
        stage_d.isShift  = isShift_d;
        stage_d.aluSrc   = aluSrc;
        stage_d.aluCtl   = aluCtl_d;
        stage_d.rd       = rdAddr;
        stage_d.rsAddr   = rsAddr;
        stage_d.rtAddr   = rtAddr;
        stage_d.shamt    = shamt;
        stage_d.rs       = rsData;
        stage_d.rt       = rtData;
        stage_d.imm      = immExt;
    end

    // flush beats stall; an invalid decode slot only bubbles if not stalled.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)                          stage_q <= '0;
        else if (flush || (!stall && !inValid)) stage_q <= '0;
        else if (!stall)                    stage_q <= stage_d;
    end

    logic [DATA_W-1:0] rsFwd, rtFwd;

`ifdef FORWARDING_EN
    // Rd!=0 in the match also guarantees register 0 is never forwarded.
    // Not gated by stall: a held instruction sees the latest results.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [4:0]        addr,
        input logic [DATA_W-1:0] regVal,
        input logic              emWe,
        input logic [4:0]        emRd,
        input logic [DATA_W-1:0] emRes,
        input logic              mwWe,
        input logic [4:0]        mwRd,
        input logic [DATA_W-1:0] mwRes
    );
        if (emWe && emRd != 5'd0 && emRd == addr)      return emRes;
        else if (mwWe && mwRd != 5'd0 && mwRd == addr) return mwRes;
        else                                           return regVal;
    endfunction

    always_comb begin
        rsFwd = fwd(stage_q.rsAddr, stage_q.rs, exMemRegWrite, exMemRd,
                    exMemResult, memWbRegWrite, memWbRd, memWbResult);
        rtFwd = fwd(stage_q.rtAddr, stage_q.rt, exMemRegWrite, exMemRd,
                    exMemResult, memWbRegWrite, memWbRd, memWbResult);
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exMemRegWrite, memWbRegWrite, exMemRd, memWbRd,
                          exMemResult, memWbResult, stage_q.rsAddr, stage_q.rtAddr};
    assign rsFwd = stage_q.rs;
    assign rtFwd = stage_q.rt;
`endif

    // sll/srl shift rt by shamt, so rt moves to in1 and shamt drives in2.
    always_comb begin
        in1 = stage_q.isShift ? rtFwd : rsFwd;
        if (stage_q.isShift)     in2 = {{(DATA_W-5){1'b0}}, stage_q.shamt};
        else if (stage_q.aluSrc) in2 = stage_q.imm;
        else                     in2 = rtFwd;
    end

    assign storeData    = rtFwd;
    assign aluControl   = stage_q.aluCtl;
    assign destRd       = stage_q.rd;
    assign regWriteOut  = stage_q.regWrite;
    assign outValid     = stage_q.valid;
    assign illegalFunct = stage_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- directed self-checking bench for id_ex_stage.
// Expected operand values follow the FORWARDING_EN setting of the build.
module tb_id_ex_stage;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN, stall, flush, inValid, aluSrc, regWriteIn;
    logic        exMemRegWrite, memWbRegWrite;
    logic [31:0] rsData, rtData, immExt, exMemResult, memWbResult;
    logic [4:0]  rsAddr, rtAddr, rdAddr, shamt, exMemRd, memWbRd;
    logic [5:0]  funct;
    logic [1:0]  aluOp;
    logic [31:0] in1, in2, storeData;
    logic [3:0]  aluControl;
    logic [4:0]  destRd;
    logic        regWriteOut, outValid, illegalFunct;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .rstN(rstN), .stall(stall), .flush(flush), .inValid(inValid),
        .rsData(rsData), .rtData(rtData), .immExt(immExt),
        .rsAddr(rsAddr), .rtAddr(rtAddr), .rdAddr(rdAddr), .shamt(shamt),
        .funct(funct), .aluOp(aluOp), .aluSrc(aluSrc), .regWriteIn(regWriteIn),
        .exMemRegWrite(exMemRegWrite), .memWbRegWrite(memWbRegWrite),
        .exMemRd(exMemRd), .memWbRd(memWbRd),
        .exMemResult(exMemResult), .memWbResult(memWbResult),
        .in1(in1), .in2(in2), .aluControl(aluControl), .storeData(storeData),
        .destRd(destRd), .regWriteOut(regWriteOut), .outValid(outValid),
        .illegalFunct(illegalFunct)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; inValid = 1; aluSrc = 0; regWriteIn = 1;
        exMemRegWrite = 0; memWbRegWrite = 0;
        rsData = 0; rtData = 0; immExt = 0; exMemResult = 0; memWbResult = 0;
        rsAddr = 0; rtAddr = 0; rdAddr = 0; shamt = 0; exMemRd = 0; memWbRd = 0;
        funct = 6'b100000; aluOp = 2'b00;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".valid"}, {31'd0, outValid}, 32'd0);
        check({tag, ".rw"},    {31'd0, regWriteOut}, 32'd0);
        check({tag, ".ill"},   {31'd0, illegalFunct}, 32'd0);
        check({tag, ".ctl"},   {28'd0, aluControl}, 32'd0);
        check({tag, ".rd"},    {27'd0, destRd}, 32'd0);
        check({tag, ".in1"},   in1, 32'd0);
        check({tag, ".in2"},   in2, 32'd0);
        check({tag, ".sd"},    storeData, 32'd0);
    endtask

    logic [5:0] fTab[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b101010, 6'b100111, 6'b000000, 6'b000010};
    logic [3:0] cTab[8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                            4'b0111, 4'b1100, 4'b1111, 4'b1110};

    initial begin
        idle();
        rstN = 0;
        rsData = 32'h1234; rtData = 32'h5678; rdAddr = 5'd9;
        #1;
        check_bubble("rst0");
        tick(); tick();
        rstN = 1;

        // slt decode
        idle();
        aluOp = 2'b10; funct = 6'b101010; rsData = 5; rtData = 9;
        rsAddr = 1; rtAddr = 2; rdAddr = 7;
        tick();
        check("slt.ctl", {28'd0, aluControl}, 32'h7);
        check("slt.in1", in1, 32'd5);
        check("slt.in2", in2, 32'd9);
        check("slt.valid", {31'd0, outValid}, 32'd1);
        check("slt.rd", {27'd0, destRd}, 32'd7);
        check("slt.rw", {31'd0, regWriteOut}, 32'd1);
        check("slt.sd", storeData, 32'd9);

        // immediate add, sub, or
        aluOp = 2'b00; aluSrc = 1; immExt = 32'h10; rtData = 32'h33;
        tick();
        check("addi.ctl", {28'd0, aluControl}, 32'h2);
        check("addi.in2", in2, 32'h10);
        check("addi.sd", storeData, 32'h33);
        aluOp = 2'b01; aluSrc = 0;
        tick();
        check("sub.ctl", {28'd0, aluControl}, 32'h6);
        check("sub.in2", in2, 32'h33);
        aluOp = 2'b11;
        tick();
        check("or.ctl", {28'd0, aluControl}, 32'h1);

        // funct table
        aluOp = 2'b10;
        for (int i = 0; i < 8; i++) begin
            funct = fTab[i];
            tick();
            check($sformatf("funct%0d.ctl", i), {28'd0, aluControl}, {28'd0, cTab[i]});
            check($sformatf("funct%0d.ill", i), {31'd0, illegalFunct}, 32'd0);
        end

        // shift: rt to in1, shamt to in2 even with aluSrc set
        funct = 6'b000000; shamt = 4; rtData = 1; rsData = 32'h55;
        aluSrc = 1; immExt = 32'hFFFF;
        tick();
        check("sll.in1", in1, 32'd1);
        check("sll.in2", in2, 32'd4);
        check("sll.ctl", {28'd0, aluControl}, 32'hF);

        // illegal funct
        funct = 6'b111111; aluSrc = 0; regWriteIn = 1;
        tick();
        check("ill.ill", {31'd0, illegalFunct}, 32'd1);
        check("ill.rw", {31'd0, regWriteOut}, 32'd0);
        check("ill.ctl", {28'd0, aluControl}, 32'h2);
        check("ill.valid", {31'd0, outValid}, 32'd1);

        // forwarding priority
        idle();
        rsAddr = 3; rsData = 32'h11; rtAddr = 4; rtData = 32'h44;
        exMemRegWrite = 1; exMemRd = 3; exMemResult = 32'hAA;
        memWbRegWrite = 1; memWbRd = 3; memWbResult = 32'hBB;
        tick();
        check("fwd.exmem", in1, FWD ? 32'hAA : 32'h11);
        check("fwd.rt_none", in2, 32'h44);
        exMemRegWrite = 0;
        #1;
        check("fwd.memwb", in1, FWD ? 32'hBB : 32'h11);
        memWbRd = 4; memWbResult = 32'hCD;
        #1;
        check("fwd.store", storeData, FWD ? 32'hCD : 32'h44);
        rsAddr = 0; rsData = 32'h22; exMemRegWrite = 1; exMemRd = 0; memWbRd = 0;
        tick();
        check("fwd.r0", in1, 32'h22);

        // forwarding tracks new results during stall
        rsAddr = 3; rsData = 32'h11; exMemRd = 3; exMemResult = 32'hAA;
        tick();
        stall = 1;
        tick();
        exMemResult = 32'hCC;
        #1;
        check("fwd.stall", in1, FWD ? 32'hCC : 32'h11);

        // stall holds, flush wins over stall
        idle();
        rsData = 32'h100; rtData = 32'h200; rsAddr = 5; rtAddr = 6; rdAddr = 4;
        tick();
        stall = 1;
        rsData = 32'hDEAD; rtData = 32'hBEEF; rdAddr = 8; aluOp = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d.in1", i), in1, 32'h100);
            check($sformatf("stall%0d.rd", i), {27'd0, destRd}, 32'd4);
            check($sformatf("stall%0d.ctl", i), {28'd0, aluControl}, 32'h2);
        end
        inValid = 0;
        tick();
        check("stall.inv.valid", {31'd0, outValid}, 32'd1);
        flush = 1; inValid = 1;
        tick();
        check_bubble("flush");

        // invalid input captured as bubble
        idle();
        rsData = 32'h77; rdAddr = 3;
        tick();
        check("valid.in1", in1, 32'h77);
        inValid = 0;
        tick();
        check_bubble("inval");

        // reset mid-stall discards held instruction
        idle();
        rsData = 32'h99; rtData = 32'h98; rdAddr = 2;
        tick();
        stall = 1;
        tick();
        #2;
        rstN = 0;
        #1;
        check_bubble("rstmid");
        tick();
        rstN = 1; stall = 0; rsData = 32'h66; rdAddr = 6;
        tick();
        check("resume.in1", in1, 32'h66);
        check("resume.rd", {27'd0, destRd}, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
